// File: rtl/obi_reg_hw_arbiter_pkg.sv
// Shared types and defaults for the hardware-side write arbiter of the OBI register block.
package obi_reg_hw_arbiter_pkg;

  localparam int unsigned HwArbNumReqs  = 4;
  localparam int unsigned HwArbNumRegs  = 4;
  localparam int unsigned HwArbIdxWidth = (HwArbNumRegs > 1) ? $clog2(HwArbNumRegs) : 1;

  typedef logic [31:0] hw_reg_t;

  typedef struct packed {
    logic [HwArbIdxWidth-1:0] idx;
    hw_reg_t                  data;
  } hw_wr_req_t;

  function automatic int unsigned rr_wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/obi_reg_hw_arbiter_rr_hw_select.sv
// Round-robin selector: one-hot grant to the first requester at or after the pointer.
module rr_hw_select #(
  parameter int unsigned NumReqs  = 4,
  parameter int unsigned PtrWidth = 2
) (
  input  logic [NumReqs-1:0]  req_i,
  input  logic [PtrWidth-1:0] ptr_i,
  output logic [NumReqs-1:0]  gnt_o
);

  logic w_found;

  // Two passes: indices from the pointer upwards, then the wrapped-around low indices.
  always_comb begin
    gnt_o   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NumReqs; i++) begin
      if (!w_found && req_i[i] && (32'(ptr_i) <= i)) begin
        gnt_o[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NumReqs; i++) begin
      if (!w_found && req_i[i] && (i < 32'(ptr_i))) begin
        gnt_o[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obi_reg_hw_arbiter.sv
// Arbitrates hardware producers onto the register block's update port, stalls reads of the
// register being written and keeps sticky collision / range-error flags.
module obi_reg_hw_arbiter
  import obi_reg_hw_arbiter_pkg::*;
#(
  parameter int unsigned NumReqs  = HwArbNumReqs,
  parameter int unsigned NumRegs  = HwArbNumRegs,
  parameter type         reg_t    = hw_reg_t,
  parameter int unsigned IdxWidth = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumReqs-1:0]                 req_i,
  input  logic [NumReqs-1:0][IdxWidth-1:0]   idx_i,
  input  reg_t [NumReqs-1:0]                 data_i,
  output logic [NumReqs-1:0]                 gnt_o,
  output logic [NumRegs-1:0]                 write_to_reg_o,
  output reg_t [NumRegs-1:0]                 regs_o,
  output logic [NumRegs-1:0]                 reg_gnt_read_o,
  input  logic [NumRegs-1:0]                 written_to_reg_i,
  output logic [NumRegs-1:0]                 collision_o,
  output logic                               range_err_o,
  input  logic                               clear_i
);

  localparam int unsigned PtrWidth = (NumReqs > 1) ? $clog2(NumReqs) : 1;

  logic [PtrWidth-1:0] r_ptr;
  logic                r_valid;
  logic [IdxWidth-1:0] r_idx;
  reg_t                r_data;
  logic [NumRegs-1:0]  r_coll;
  logic                r_range_err;

  logic [NumReqs-1:0]  w_sel;
  logic                w_xfer;
  logic [PtrWidth-1:0] w_win;
  logic [IdxWidth-1:0] w_idx;
  reg_t                w_data;
  logic                w_stage;
  logic                w_in_range;
  logic [NumRegs-1:0]  w_coll_set;
  logic                w_rerr_set;

  rr_hw_select #(
    .NumReqs  (NumReqs),
    .PtrWidth (PtrWidth)
  ) u_rr_hw_select (
    .req_i (req_i),
    .ptr_i (r_ptr),
    .gnt_o (w_sel)
  );

  assign gnt_o  = rst_i ? '0 : w_sel;
  assign w_xfer = |(req_i & gnt_o);

  always_comb begin
    w_win  = '0;
    w_idx  = '0;
    w_data = '0;
    for (int unsigned i = 0; i < NumReqs; i++) begin
      if (gnt_o[i]) begin
        w_win  = PtrWidth'(i);
        w_idx  = idx_i[i];
        w_data = data_i[i];
      end
    end
  end

  // Reset masks the write stage so an in-flight write never reaches the register block.
  assign w_stage    = r_valid && !rst_i;
  assign w_in_range = (32'(r_idx) < NumRegs);
  assign w_rerr_set = w_stage && !w_in_range;

  always_comb begin
    write_to_reg_o = '0;
    regs_o         = '0;
    reg_gnt_read_o = '1;
    w_coll_set     = '0;
    for (int unsigned k = 0; k < NumRegs; k++) begin
      if (w_stage && w_in_range && (32'(r_idx) == k)) begin
        write_to_reg_o[k] = 1'b1;
        regs_o[k]         = r_data;
        reg_gnt_read_o[k] = 1'b0;
        w_coll_set[k]     = written_to_reg_i[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr       <= '0;
      r_valid     <= 1'b0;
      r_idx       <= '0;
      r_data      <= '0;
      r_coll      <= '0;
      r_range_err <= 1'b0;
    end else begin
      r_valid <= w_xfer;
      if (w_xfer) begin
        r_ptr  <= PtrWidth'(rr_wrap_inc(32'(w_win), NumReqs));
        r_idx  <= w_idx;
        r_data <= w_data;
      end
      // A new set in the same cycle as clear_i wins.
      r_coll      <= w_coll_set | (r_coll & ~{NumRegs{clear_i}});
      r_range_err <= w_rerr_set | (r_range_err & ~clear_i);
    end
  end

  assign collision_o = r_coll;
  assign range_err_o = r_range_err;

endmodule

// File: tb/tb_obi_reg_hw_arbiter.sv
// Randomised and directed checks of obi_reg_hw_arbiter against a cycle-level behavioural model.
module tb_obi_reg_hw_arbiter;

  localparam int NQ = 4;
  localparam int NG = 4;
  localparam int IW = 3;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic [NQ-1:0]            req_i;
  logic [NQ-1:0][IW-1:0]    idx_i;
  logic [NQ-1:0][31:0]      data_i;
  logic [NQ-1:0]            gnt_o;
  logic [NG-1:0]            write_to_reg_o;
  logic [NG-1:0][31:0]      regs_o;
  logic [NG-1:0]            reg_gnt_read_o;
  logic [NG-1:0]            written_to_reg_i;
  logic [NG-1:0]            collision_o;
  logic                     range_err_o;
  logic                     clear_i;

  always #5 clk_i = ~clk_i;

  obi_reg_hw_arbiter #(
    .NumReqs  (NQ),
    .NumRegs  (NG),
    .IdxWidth (IW)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_i            (req_i),
    .idx_i            (idx_i),
    .data_i           (data_i),
    .gnt_o            (gnt_o),
    .write_to_reg_o   (write_to_reg_o),
    .regs_o           (regs_o),
    .reg_gnt_read_o   (reg_gnt_read_o),
    .written_to_reg_i (written_to_reg_i),
    .collision_o      (collision_o),
    .range_err_o      (range_err_o),
    .clear_i          (clear_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Behavioural model: pending requests per producer, the pending write, sticky flags, memory image.
  bit          pend   [NQ];
  int          p_idx  [NQ];
  logic [31:0] p_data [NQ];
  int          m_ptr;
  bit          m_valid;
  int          m_idx;
  logic [31:0] m_data;
  bit [NG-1:0] m_coll;
  bit          m_rerr;
  logic [31:0] m_mem [NG];
  logic [31:0] d_mem [NG];

  task automatic post(input int q, input int idx, input logic [31:0] data);
    pend[q]   = 1'b1;
    p_idx[q]  = idx;
    p_data[q] = data;
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_data  = '0;
    m_coll  = '0;
    m_rerr  = 1'b0;
  endtask

  task automatic cycle(input bit rst, input logic [NG-1:0] wr, input bit clr);
    int          win;
    bit          stage;
    bit          inr;
    logic [31:0] e_wr;
    rst_i            = rst;
    written_to_reg_i = wr;
    clear_i          = clr;
    for (int q = 0; q < NQ; q++) begin
      req_i[q]  = pend[q];
      idx_i[q]  = IW'(p_idx[q]);
      data_i[q] = p_data[q];
    end
    #4;
    win = -1;
    if (!rst) begin
      for (int k = 0; k < NQ; k++) begin
        if (win < 0 && pend[(m_ptr + k) % NQ]) win = (m_ptr + k) % NQ;
      end
    end
    stage = m_valid && !rst;
    inr   = (m_idx < NG);
    e_wr  = (stage && inr) ? (32'd1 << m_idx) : 32'd0;
    check("gnt", 32'(gnt_o), (win < 0) ? 32'd0 : (32'd1 << win));
    check("write_to_reg", 32'(write_to_reg_o), e_wr);
    check("reg_gnt_read", 32'(reg_gnt_read_o), ~e_wr & 32'hF);
    for (int k = 0; k < NG; k++) begin
      check($sformatf("regs[%0d]", k), regs_o[k], e_wr[k] ? m_data : 32'd0);
      if (write_to_reg_o[k]) d_mem[k] = regs_o[k];
    end
    check("collision", 32'(collision_o), 32'(m_coll));
    check("range_err", 32'(range_err_o), 32'(m_rerr));
    if (rst) begin
      model_reset();
    end else begin
      if (clr) begin
        m_coll = '0;
        m_rerr = 1'b0;
      end
      if (stage && inr) begin
        m_mem[m_idx] = m_data;
        if (wr[m_idx]) m_coll[m_idx] = 1'b1;
      end
      if (stage && !inr) m_rerr = 1'b1;
      m_valid = (win >= 0);
      if (win >= 0) begin
        m_idx     = p_idx[win];
        m_data    = p_data[win];
        m_ptr     = (win + 1) % NQ;
        pend[win] = 1'b0;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int q = 0; q < NQ; q++) begin
      pend[q]   = 1'b0;
      p_idx[q]  = 0;
      p_data[q] = '0;
    end
    for (int k = 0; k < NG; k++) begin
      m_mem[k] = '0;
      d_mem[k] = '0;
    end
    model_reset();
    rst_i = 1'b1; clear_i = 1'b0; written_to_reg_i = '0;
    req_i = '0; idx_i = '0; data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    cycle(1, '0, 0);

    // Single request to register 2.
    post(0, 2, 32'hDEAD_BEEF);
    repeat (3) cycle(0, '0, 0);

    // Fairness: everyone requesting continuously from a fresh pointer.
    cycle(1, '0, 0);
    for (int q = 0; q < NQ; q++) post(q, q, 32'h100 + q);
    for (int n = 0; n < 9; n++) begin
      cycle(0, '0, 0);
      for (int q = 0; q < NQ; q++) if (!pend[q]) post(q, q, 32'h200 + n);
    end
    for (int q = 0; q < NQ; q++) pend[q] = 1'b0;
    repeat (2) cycle(0, '0, 0);

    // Back-to-back writes to register 0.
    post(1, 0, 32'd1);
    cycle(0, '0, 0);
    post(1, 0, 32'd2);
    repeat (3) cycle(0, '0, 0);
    check("b2b_final", d_mem[0], 32'd2);

    // Collision on register 3, then clear.
    post(2, 3, 32'hCAFE_0003);
    cycle(0, '0, 0);
    cycle(0, 4'b1000, 0);
    cycle(0, '0, 0);
    cycle(0, '0, 1);
    cycle(0, '0, 0);

    // Out of range at the boundary and at the top of the index space.
    post(3, NG, 32'h1111_1111);
    repeat (3) cycle(0, '0, 0);
    post(0, 7, 32'h2222_2222);
    repeat (2) cycle(0, '0, 1);
    cycle(0, '0, 0);

    // Clear and a new collision in the same cycle: the set wins.
    post(0, 1, 32'h3333_3333);
    cycle(0, '0, 0);
    cycle(0, 4'b0010, 1);
    cycle(0, '0, 0);

    // Reset in the write-stage cycle discards the write.
    post(1, 2, 32'h4444_4444);
    cycle(0, '0, 0);
    cycle(1, '0, 0);
    cycle(0, '0, 0);
    check("rst_discard", d_mem[2], m_mem[2]);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int q = 0; q < NQ; q++) begin
        if (!pend[q] && $urandom_range(0, 1) == 1) post(q, $urandom_range(0, 5), $urandom);
      end
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) == 0) ? NG'($urandom_range(0, 15)) : '0,
            ($urandom_range(0, 15) == 0));
    end

    for (int k = 0; k < NG; k++) check($sformatf("mem[%0d]", k), d_mem[k], m_mem[k]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
